// File: rtl/load_store_unit.sv
// load_store_unit: sequences byte/half/word loads and stores into a word-addressed data memory
module load_store_unit #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_read_data
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] ST_WR  = 3'd2;
    localparam logic [2:0] RMW_RD = 3'd3;
    localparam logic [2:0] RMW_WR = 3'd4;

    logic [2:0]  state;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [31:0] merge;
    logic        accept;
    logic        req_err;
    logic [4:0]  sh;
    logic [31:0] lane_mask;
    logic [31:0] merged;
    logic [31:0] shifted;
    logic [31:0] ext;

    assign req_ready = state == IDLE;
    assign accept    = req_valid & req_ready;

    // Memory-side controls come only from state and latched fields, never from req_*
    assign mem_read       = state == LOAD || state == RMW_RD;
    assign mem_write      = state == ST_WR || state == RMW_WR;
    assign mem_address    = state == IDLE ? 32'd0 : {lat_addr[31:2], 2'b00};
    assign mem_write_data = state == ST_WR ? lat_wdata : state == RMW_WR ? merged : 32'd0;

    // Request legality: illegal size, misalignment, or beyond the end of memory
    always_comb begin
        req_err = req_size == 2'b11 ||
                  (req_size == 2'b01 && req_addr[0]) ||
                  (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                  req_addr >= 32'(MEM_BYTES);
    end

    // Lane shift/mask for the latched access; byte lane uses addr[1:0], half lane uses addr[1]
    always_comb begin
        sh        = lat_size == 2'b00 ? {lat_addr[1:0], 3'b000} : {lat_addr[1], 4'b0000};
        lane_mask = lat_size == 2'b00 ? 32'h0000_00FF << sh : 32'h0000_FFFF << sh;
        merged    = (merge & ~lane_mask) | ((lat_wdata << sh) & lane_mask);
        shifted   = mem_read_data >> sh;
        ext       = lat_size == 2'b10 ? mem_read_data :
                    lat_size == 2'b01 ? {{16{~lat_unsigned & shifted[15]}}, shifted[15:0]} :
                                        {{24{~lat_unsigned & shifted[7]}}, shifted[7:0]};
    end

    // Request FSM, field latches, merge register and registered response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            lat_addr     <= 32'd0;
            lat_wdata    <= 32'd0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            merge        <= 32'd0;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'd0;
            resp_error   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    lat_addr     <= req_addr;
                    lat_wdata    <= req_wdata;
                    lat_size     <= req_size;
                    lat_unsigned <= req_unsigned;
                    if (req_err) begin
                        resp_valid <= 1'b1;
                        resp_error <= 1'b1;
                        resp_rdata <= 32'd0;
                    end else begin
                        state <= !req_write ? LOAD : req_size == 2'b10 ? ST_WR : RMW_RD;
                    end
                end
                LOAD: begin
                    resp_valid <= 1'b1;
                    resp_error <= 1'b0;
                    resp_rdata <= ext;
                    state      <= IDLE;
                end
                RMW_RD: begin
                    merge <= mem_read_data;
                    state <= RMW_WR;
                end
                ST_WR, RMW_WR: begin
                    resp_valid <= 1'b1;
                    resp_error <= 1'b0;
                    resp_rdata <= 32'd0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit with a behavioural data memory
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_read_data;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = 8'd0;
    logic [31:0] pl_data = 32'd0;
    logic        mr_hist [9];
    logic        mw_hist [9];
    logic [31:0] wd_hist [9];

    load_store_unit dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_error(resp_error), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_write(mem_write), .mem_read(mem_read),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_address[9:2]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_address[9:2]] <= mem_write_data;
        else if (pl_en) mem[pl_idx] <= pl_data;
    end

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic send_raw(input logic w, input logic [1:0] sz, input logic u,
                            input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
    endtask

    task automatic send(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_er);
        sb.push_back('{exp_rd, exp_er});
        send_raw(w, sz, u, a, wd);
    endtask

    task automatic wait_resp(output int lat, output logic [31:0] rd, output logic er);
        lat = -1; rd = 32'd0; er = 1'b0;
        for (int c = 0; c < 9; c++) begin
            mr_hist[c] = 1'b0; mw_hist[c] = 1'b0; wd_hist[c] = 32'd0;
        end
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            mr_hist[c] = mem_read; mw_hist[c] = mem_write; wd_hist[c] = mem_write_data;
            if (resp_valid) begin
                lat = c; rd = resp_rdata; er = resp_error;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_error, mem_read, mem_write} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 10000", {req_ready, resp_valid, resp_error, mem_read, mem_write});
        end
        checks++;
        if ({resp_rdata, mem_address, mem_write_data} !== 96'd0) begin
            errors++;
            $display("FAIL reset_data got %h/%h/%h exp 0", resp_rdata, mem_address, mem_write_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_loads;
        logic [1:0]  sz [7];
        logic        un [7];
        logic [31:0] ad [7];
        logic [31:0] ex [7];
        int lat; logic [31:0] rd; logic er; exp_t e;
        sz = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
        un = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        ad = '{32'h4, 32'h5, 32'h6, 32'h7, 32'h6, 32'h6, 32'h4};
        ex = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'h00000080,
               32'hFFFF80FF, 32'h000080FF, 32'h80FF7F01};
        preload(8'd1, 32'h80FF7F01);
        for (int i = 0; i < 7; i++) begin
            send(1'b0, sz[i], un[i], ad[i], 32'hDEADBEEF, ex[i], 1'b0);
            wait_resp(lat, rd, er);
            e = sb.pop_front();
            checks++;
            if (lat !== 2 || mr_hist[1] !== 1'b1) begin
                errors++;
                $display("FAIL load_timing[%0d] got lat=%0d rd=%b exp lat=2 rd=1", i, lat, mr_hist[1]);
            end
            checks++;
            if ({rd, er} !== {e.rdata, e.err}) begin
                errors++;
                $display("FAIL load_data[%0d] got %h err=%b exp %h err=%b", i, rd, er, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_substore;
        int lat; logic [31:0] rd; logic er; exp_t e;
        preload(8'd2, 32'h11223344);
        send(1'b1, 2'b00, 1'b0, 32'h9, 32'hFFFFFFAB, 32'd0, 1'b0);
        wait_resp(lat, rd, er);
        e = sb.pop_front();
        checks++;
        if (lat !== 3 || mr_hist[1] !== 1'b1 || mw_hist[1] !== 1'b0 || mw_hist[2] !== 1'b1) begin
            errors++;
            $display("FAIL sb_timing got lat=%0d rd1=%b wr1=%b wr2=%b exp 3/1/0/1", lat, mr_hist[1], mw_hist[1], mw_hist[2]);
        end
        checks++;
        if (wd_hist[2] !== 32'h1122AB44 || mem[2] !== 32'h1122AB44) begin
            errors++;
            $display("FAIL sb_data got bus=%h mem=%h exp 1122ab44", wd_hist[2], mem[2]);
        end
        checks++;
        if ({rd, er} !== {e.rdata, e.err}) begin
            errors++;
            $display("FAIL sb_resp got %h err=%b exp %h err=%b", rd, er, e.rdata, e.err);
        end
        send(1'b1, 2'b01, 1'b0, 32'hA, 32'h1234BEEF, 32'd0, 1'b0);
        wait_resp(lat, rd, er);
        e = sb.pop_front();
        checks++;
        if (lat !== 3 || mem[2] !== 32'hBEEFAB44 || {rd, er} !== {e.rdata, e.err}) begin
            errors++;
            $display("FAIL sh_store got lat=%0d mem=%h rd=%h exp 3/beefab44/%h", lat, mem[2], rd, e.rdata);
        end
        send(1'b1, 2'b10, 1'b0, 32'hC, 32'hCAFEF00D, 32'd0, 1'b0);
        wait_resp(lat, rd, er);
        e = sb.pop_front();
        checks++;
        if (lat !== 2 || mw_hist[1] !== 1'b1 || mem[3] !== 32'hCAFEF00D || {rd, er} !== {e.rdata, e.err}) begin
            errors++;
            $display("FAIL sw_store got lat=%0d wr=%b mem=%h exp 2/1/cafef00d", lat, mw_hist[1], mem[3]);
        end
    endtask

    task automatic test_errors;
        logic        wr [4];
        logic [1:0]  sz [4];
        logic [31:0] ad [4];
        int lat; logic [31:0] rd; logic er; exp_t e;
        wr = '{1'b1, 1'b0, 1'b0, 1'b0};
        sz = '{2'b10, 2'b01, 2'b11, 2'b10};
        ad = '{32'h6, 32'h3, 32'h0, 32'h400};
        for (int i = 0; i < 4; i++) begin
            send(wr[i], sz[i], 1'b0, ad[i], 32'h55555555, 32'd0, 1'b1);
            wait_resp(lat, rd, er);
            e = sb.pop_front();
            checks++;
            if (lat !== 1 || mr_hist[1] !== 1'b0 || mw_hist[1] !== 1'b0) begin
                errors++;
                $display("FAIL err_timing[%0d] got lat=%0d rd=%b wr=%b exp 1/0/0", i, lat, mr_hist[1], mw_hist[1]);
            end
            checks++;
            if ({rd, er} !== {e.rdata, e.err}) begin
                errors++;
                $display("FAIL err_resp[%0d] got %h err=%b exp %h err=%b", i, rd, er, e.rdata, e.err);
            end
        end
        checks++;
        if (mem[1] !== 32'h80FF7F01) begin
            errors++;
            $display("FAIL err_mem got %h exp 80ff7f01", mem[1]);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        sb.push_back('{32'h00000001, 1'b0});
        send_raw(1'b0, 2'b00, 1'b0, 32'h4, 32'd0);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy got ready=%b valid=%b exp 0/0", req_ready, resp_valid);
        end
        sb.push_back('{32'h80FF7F01, 1'b0});
        req_size = 2'b10;
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (resp_valid !== 1'b1 || req_ready !== 1'b1 || resp_rdata !== e.rdata) begin
            errors++;
            $display("FAIL b2b_first got v=%b rdy=%b rd=%h exp 1/1/%h", resp_valid, req_ready, resp_rdata, e.rdata);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap got v=%b rdy=%b exp 0/0", resp_valid, req_ready);
        end
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || resp_error !== e.err) begin
            errors++;
            $display("FAIL b2b_second got v=%b rd=%h exp 1/%h", resp_valid, resp_rdata, e.rdata);
        end
    endtask

    task automatic test_reset_mid_rmw;
        logic seen;
        send_raw(1'b1, 2'b00, 1'b0, 32'h8, 32'h12);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b1) begin
            errors++;
            $display("FAIL rst_rmw_pre got mem_write=%b exp 1", mem_write);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b0) begin
            errors++;
            $display("FAIL rst_rmw_drop got mem_write=%b exp 0", mem_write);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | resp_valid;
        end
        checks++;
        if (seen !== 1'b0 || req_ready !== 1'b1 || mem[2] !== 32'hBEEFAB44) begin
            errors++;
            $display("FAIL rst_rmw_after got resp=%b rdy=%b mem=%h exp 0/1/beefab44", seen, req_ready, mem[2]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_loads();
        test_substore();
        test_errors();
        test_back_to_back();
        test_reset_mid_rmw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
